// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter: opcodes, flag bit positions, FSM states.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package alu_pkg;

    localparam logic [5:0] ALUC_ADD  = 6'b100000;
    localparam logic [5:0] ALUC_ADDU = 6'b100001;
    localparam logic [5:0] ALUC_SUB  = 6'b100010;
    localparam logic [5:0] ALUC_SUBU = 6'b100011;
    localparam logic [5:0] ALUC_AND  = 6'b100100;
    localparam logic [5:0] ALUC_OR   = 6'b100101;
    localparam logic [5:0] ALUC_XOR  = 6'b100110;
    localparam logic [5:0] ALUC_NOR  = 6'b100111;
    localparam logic [5:0] ALUC_SLT  = 6'b101010;
    localparam logic [5:0] ALUC_SLTU = 6'b101011;
    localparam logic [5:0] ALUC_SLL  = 6'b000000;
    localparam logic [5:0] ALUC_SRL  = 6'b000010;
    localparam logic [5:0] ALUC_SRA  = 6'b000011;
    localparam logic [5:0] ALUC_SLLV = 6'b000100;
    localparam logic [5:0] ALUC_SRLV = 6'b000110;
    localparam logic [5:0] ALUC_SRAV = 6'b000111;
    localparam logic [5:0] ALUC_LUI  = 6'b001111;

    // Flag vector is {zero, carry, negative, overflow, flag}
    localparam int FLG_W     = 5;
    localparam int FLG_ZERO  = 4;
    localparam int FLG_CARRY = 3;
    localparam int FLG_NEG   = 2;
    localparam int FLG_OVF   = 1;
    localparam int FLG_FLAG  = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // True for opcodes the shared ALU implements; anything else is reported as an error
    function automatic logic aluc_supported(input logic [5:0] aluc);
        case (aluc)
            ALUC_ADD, ALUC_ADDU, ALUC_SUB, ALUC_SUBU,
            ALUC_AND, ALUC_OR, ALUC_XOR, ALUC_NOR,
            ALUC_SLT, ALUC_SLTU,
            ALUC_SLL, ALUC_SRL, ALUC_SRA,
            ALUC_SLLV, ALUC_SRLV, ALUC_SRAV,
            ALUC_LUI: aluc_supported = 1'b1;
            default:  aluc_supported = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first valid requester at or after ptr, wrapping; one-hot grant + index.
// Latency: purely combinational.
// Backpressure: none; caller gates the grant with its own accept condition.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx
);

    logic [IW-1:0] sel;
    logic          found;

    // Scan from ptr upward, wrapping, and take the first valid requester
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < NREQ; k++) begin
            sel = IW'((int'(ptr) + k) % NREQ);
            if (!found && valid[sel]) begin
                found      = 1'b1;
                grant[sel] = 1'b1;
                idx        = sel;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NREQ requesters with round-robin grant.
// Latency: accept cycle n -> ALU driven in n+1 -> resp_valid from cycle n+2; max 1 op / 3 cycles.
// Backpressure: result held until resp_ready of the granted requester; req_ready low meanwhile.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*W-1:0]    req_a,
    input  logic [NREQ*W-1:0]    req_b,
    input  logic [NREQ*6-1:0]    req_aluc,
    output logic [W-1:0]         alu_a,
    output logic [W-1:0]         alu_b,
    output logic [5:0]           alu_aluc,
    input  logic [W-1:0]         alu_r,
    input  logic [FLG_W-1:0]     alu_flags,
    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [W-1:0]         resp_r,
    output logic [FLG_W-1:0]     resp_flags,
    output logic                 resp_err
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t        state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] grant_idx;
    logic [IW-1:0] arb_idx;
    logic [NREQ-1:0] arb_grant;
    logic [W-1:0]  lat_a;
    logic [W-1:0]  lat_b;
    logic [5:0]    lat_aluc;
    logic          accept;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_arbiter (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    // Grant is only offered while idle; reset also masks it so nothing is accepted that cycle
    assign req_ready = (state == ST_IDLE && !rst) ? arb_grant : '0;
    assign accept    = |(req_valid & req_ready);

    // ALU inputs come straight from the operand latches, so they stay quiet while idle
    assign alu_a    = lat_a;
    assign alu_b    = lat_b;
    assign alu_aluc = lat_aluc;

    // Control FSM: latch on accept, capture ALU outputs after one EXEC cycle, hold until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            grant_idx  <= '0;
            lat_a      <= '0;
            lat_b      <= '0;
            lat_aluc   <= ALUC_ADD;
            resp_valid <= '0;
            resp_r     <= '0;
            resp_flags <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat_a     <= req_a[arb_idx*W +: W];
                        lat_b     <= req_b[arb_idx*W +: W];
                        lat_aluc  <= req_aluc[arb_idx*6 +: 6];
                        grant_idx <= arb_idx;
                        state     <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    resp_valid <= NREQ'(1) << grant_idx;
                    // Unsupported opcodes still drive the ALU, but its output is discarded
                    if (aluc_supported(lat_aluc)) begin
                        resp_r     <= alu_r;
                        resp_flags <= alu_flags;
                        resp_err   <= 1'b0;
                    end else begin
                        resp_r     <= '0;
                        resp_flags <= '0;
                        resp_err   <= 1'b1;
                    end
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready[grant_idx]) begin
                        resp_valid <= '0;
                        rr_ptr     <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a behavioural ALU on the alu_* ports.
// Latency: n/a.
// Backpressure: resp_ready driven randomly and in directed stall windows.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam int NREQ = 2;
    localparam int W    = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a = '0;
    logic [NREQ*W-1:0] req_b = '0;
    logic [NREQ*6-1:0] req_aluc = '0;
    logic [W-1:0]      alu_a, alu_b, alu_r;
    logic [5:0]        alu_aluc;
    logic [4:0]        alu_flags;
    logic [NREQ-1:0]   resp_valid;
    logic [NREQ-1:0]   resp_ready = '0;
    logic [W-1:0]      resp_r;
    logic [4:0]        resp_flags;
    logic              resp_err;

    alu_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_aluc   (req_aluc),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_aluc   (alu_aluc),
        .alu_r      (alu_r),
        .alu_flags  (alu_flags),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_r     (resp_r),
        .resp_flags (resp_flags),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [31:0] r;
        logic [4:0] flags;
        logic [4:0] fmask;
        logic       err;
        int         acc_cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   model_busy = 0;
    int   model_ptr = 0;
    bit   seen = 0;
    bit   use_ovr = 0;
    int   ovr_idx = 0;
    logic [31:0] ovr_r = '0;
    logic [4:0]  ovr_flags = '0;
    logic [4:0]  ovr_mask = '0;

    logic [5:0] sup_list [17] = '{ALUC_ADD, ALUC_ADDU, ALUC_SUB, ALUC_SUBU, ALUC_AND, ALUC_OR,
                                  ALUC_XOR, ALUC_NOR, ALUC_SLT, ALUC_SLTU, ALUC_SLL, ALUC_SRL,
                                  ALUC_SRA, ALUC_SLLV, ALUC_SRLV, ALUC_SRAV, ALUC_LUI};

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the real ALU: returns {zero,carry,negative,overflow,flag, r}
    function automatic logic [36:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [5:0] c);
        logic [32:0] s;
        logic [31:0] r;
        logic cy, ov, fl;
        s = '0; r = '0; cy = 1'b0; ov = 1'b0; fl = 1'b0;
        case (c)
            ALUC_ADD, ALUC_ADDU: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0]; cy = s[32];
                ov = (a[31] == b[31]) && (r[31] != a[31]);
            end
            ALUC_SUB, ALUC_SUBU: begin
                r = a - b; cy = (a < b);
                ov = (a[31] != b[31]) && (r[31] != a[31]);
            end
            ALUC_AND: r = a & b;
            ALUC_OR:  r = a | b;
            ALUC_XOR: r = a ^ b;
            ALUC_NOR: r = ~(a | b);
            ALUC_SLT:  begin fl = ($signed(a) < $signed(b)); r = {31'b0, fl}; end
            ALUC_SLTU: begin fl = (a < b); r = {31'b0, fl}; end
            ALUC_SLL, ALUC_SLLV: r = b << a[4:0];
            ALUC_SRL, ALUC_SRLV: r = b >> a[4:0];
            ALUC_SRA, ALUC_SRAV: r = $signed(b) >>> a[4:0];
            ALUC_LUI: r = {b[15:0], 16'h0};
            default: begin r = 32'hdeadbeef; cy = 1'b1; ov = 1'b1; fl = 1'b1; end
        endcase
        return {(r == 32'h0), cy, r[31], ov, fl, r};
    endfunction

    always_comb begin
        {alu_flags, alu_r} = alu_fn(alu_a, alu_b, alu_aluc);
    end

    function automatic bit is_sup(input logic [5:0] c);
        for (int i = 0; i < 17; i++) if (sup_list[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic exp_t ref_model(input int idx, input logic [31:0] a, input logic [31:0] b,
                                       input logic [5:0] c, input int acc);
        exp_t e;
        logic [36:0] fr;
        e.idx = idx; e.acc_cyc = acc; e.fmask = 5'h1f;
        if (is_sup(c)) begin
            fr = alu_fn(a, b, c);
            e.r = fr[31:0]; e.flags = fr[36:32]; e.err = 1'b0;
        end else begin
            e.r = '0; e.flags = '0; e.err = 1'b1;
        end
        return e;
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    task automatic chk_reset_vals();
        chk("rst_req_ready", req_ready, '0);
        chk("rst_resp_valid", resp_valid, '0);
        chk("rst_resp_r", resp_r, '0);
        chk("rst_resp_flags", resp_flags, '0);
        chk("rst_resp_err", resp_err, '0);
        chk("rst_alu_a", alu_a, '0);
        chk("rst_alu_b", alu_b, '0);
        chk("rst_alu_aluc", alu_aluc, ALUC_ADD);
    endtask

    // One clock of stimulus; predicts the grant and queues the expected response on accept
    task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*W-1:0] a,
                        input logic [NREQ*W-1:0] b, input logic [NREQ*6-1:0] c,
                        input logic [NREQ-1:0] rr);
        int g;
        exp_t e;
        logic [NREQ-1:0] er;
        @(posedge clk); #1;
        req_valid = v; req_a = a; req_b = b; req_aluc = c; resp_ready = rr;
        #1;
        g = model_busy ? -1 : rr_pick(v, model_ptr);
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", req_ready, er);
        if (g >= 0) begin
            e = ref_model(g, a[g*W +: W], b[g*W +: W], c[g*6 +: 6], cyc);
            if (use_ovr && ovr_idx == g) begin
                e.r = ovr_r; e.flags = ovr_flags; e.fmask = ovr_mask; use_ovr = 0;
            end
            q.push_back(e);
            model_busy = 1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; req_valid = '0; resp_ready = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete(); seen = 0; model_busy = 0; model_ptr = 0;
        #1;
        chk_reset_vals();
    endtask

    task automatic set_ovr(input int idx, input logic [31:0] r, input logic [4:0] f, input logic [4:0] m);
        use_ovr = 1; ovr_idx = idx; ovr_r = r; ovr_flags = f; ovr_mask = m;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (model_busy && n < 30) begin step('0, req_a, req_b, req_aluc, '1); n++; end
        if (model_busy) timeout_fail(name);
    endtask

    // Offer one op on requester idx until accepted, then collect its response
    task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b, input logic [5:0] c);
        logic [NREQ*W-1:0] av, bv;
        logic [NREQ*6-1:0] cv;
        logic [NREQ-1:0]   v;
        int n;
        av = req_a; bv = req_b; cv = req_aluc;
        av[idx*W +: W] = a; bv[idx*W +: W] = b; cv[idx*6 +: 6] = c;
        v = '0; v[idx] = 1'b1;
        n = 0;
        while (!model_busy && n < 20) begin step(v, av, bv, cv, '0); n++; end
        if (!model_busy) timeout_fail("accept");
        drain("response");
    endtask

    function automatic logic [5:0] rand_aluc();
        if ($urandom_range(3) == 0) return 6'($urandom_range(63));
        return sup_list[$urandom_range(16)];
    endfunction

    // Monitor: compare every presented response against the head of the scoreboard
    initial begin : monitor
        exp_t e;
        logic [NREQ-1:0] oh;
        forever begin
            @(negedge clk);
            if (!rst && resp_valid != '0) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_resp: resp_valid=%b with no outstanding op (cycle %0d)", resp_valid, cyc);
                end else begin
                    e = q[0];
                    oh = '0; oh[e.idx] = 1'b1;
                    chk("resp_valid", resp_valid, oh);
                    chk("resp_r", resp_r, e.r);
                    chk("resp_flags", resp_flags & e.fmask, e.flags & e.fmask);
                    chk("resp_err", resp_err, e.err);
                    if (!seen) begin
                        chk("latency", cyc - e.acc_cyc, 2);
                        seen = 1;
                    end
                    if (resp_ready[e.idx]) begin
                        void'(q.pop_front());
                        seen = 0;
                        @(posedge clk);
                        model_busy = 0;
                        model_ptr = (e.idx + 1) % NREQ;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [NREQ*W-1:0] ra, rb;
        logic [NREQ*6-1:0] rc;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk_reset_vals();

        // ADD, SUB, SLT, SLTU with the reference operand pair
        set_ovr(0, 32'h3d, 5'h0, 5'(1 << FLG_ZERO));
        run_op(0, 32'h1c, 32'h21, ALUC_ADD);
        set_ovr(1, 32'hfffffffb, 5'(1 << FLG_NEG), 5'(1 << FLG_NEG));
        run_op(1, 32'h1c, 32'h21, ALUC_SUB);
        set_ovr(1, 32'h1, 5'h0, 5'h0);
        run_op(1, 32'h1c, 32'h21, ALUC_SLT);
        set_ovr(1, 32'h1, 5'h0, 5'h0);
        run_op(1, 32'h1c, 32'h21, ALUC_SLTU);

        // Both requesters held valid from reset: grants must alternate starting at 0
        do_reset();
        for (int i = 0; i < 12; i++) begin
            ra = {$urandom(), $urandom()}; rb = {$urandom(), $urandom()};
            rc = {rand_aluc(), rand_aluc()};
            step('1, ra, rb, rc, '1);
        end
        drain("alternate");

        // Long response stall: output held, no new accept while both keep requesting
        step(2'b01, {32'h5, 32'h7}, {32'h9, 32'h3}, {ALUC_XOR, ALUC_SUB}, '0);
        for (int i = 0; i < 7; i++) step('1, req_a, req_b, req_aluc, '0);
        drain("stall");

        // Unsupported opcode, then a normal op must clear the error
        run_op(1, 32'h12345678, 32'h1, 6'b111111);
        run_op(1, 32'h5, 32'h7, ALUC_ADD);

        // Reset during EXEC after moving the pointer off 0
        run_op(0, 32'h1, 32'h2, ALUC_OR);
        step(2'b10, req_a, req_b, req_aluc, '0);
        do_reset();
        for (int i = 0; i < 4; i++) step('0, req_a, req_b, req_aluc, '1);
        step('1, req_a, req_b, req_aluc, '1);
        drain("post_reset_exec");

        // Reset while holding a response in RESP
        step(2'b10, {32'h44, 32'h0}, {32'h4, 32'h0}, {ALUC_SLL, ALUC_ADD}, '0);
        step('0, req_a, req_b, req_aluc, '0);
        step('0, req_a, req_b, req_aluc, '0);
        do_reset();
        for (int i = 0; i < 4; i++) step('0, req_a, req_b, req_aluc, '1);
        step('1, req_a, req_b, req_aluc, '1);
        drain("post_reset_resp");

        // Random traffic with random backpressure
        for (int i = 0; i < 600; i++) begin
            ra = {$urandom(), $urandom()}; rb = {$urandom(), $urandom()};
            rc = {rand_aluc(), rand_aluc()};
            step(NREQ'($urandom_range(3)), ra, rb, rc, NREQ'($urandom_range(3)));
        end
        drain("final");
        step('0, req_a, req_b, req_aluc, '1);
        chk("queue_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
